// File: rtl/miriscv_mem_arbiter.sv
// rtl/miriscv_mem_arbiter.sv - single-outstanding instr/data memory port arbiter
// Data side wins by default; instr is forced through after STARVE_LIMIT consecutive data grants.
package miriscv_pkg;
    parameter int XLEN = 32;
endpackage

module miriscv_mem_arbiter #(
    parameter int XLEN         = miriscv_pkg::XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    input  logic              instr_kill_i,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              busy_o
);

    localparam int              CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_e;

    state_e        state_q, state_d;
    logic          drop_q;
    logic [CW-1:0] cnt_q;
    logic          instr_valid;
    logic          data_win;
    logic          instr_win;

    // A fetch killed in the same cycle it is presented never competes.
    assign instr_valid = instr_req_i & ~instr_kill_i;
    assign data_win    = (state_q == IDLE) & data_req_i & (~instr_valid | (cnt_q < CNT_MAX));
    assign instr_win   = (state_q == IDLE) & instr_valid & ~data_win;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (data_win) begin
                    state_d = WAIT_D;
                end else if (instr_win) begin
                    state_d = WAIT_I;
                end
            end
            WAIT_I, WAIT_D: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        busy_o         = (state_q != IDLE);
        unique case (state_q)
            WAIT_I:  instr_rvalid_o = mem_rvalid_i & ~drop_q & ~instr_kill_i;
            WAIT_D:  data_rvalid_o  = mem_rvalid_i;
            default: ;
        endcase
    end

    assign instr_rdata_o = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_req_o <= data_win | instr_win;
            if (data_win) begin
                mem_we_o    <= data_we_i;
                mem_be_o    <= data_be_i;
                mem_addr_o  <= data_addr_i;
                mem_wdata_o <= data_wdata_i;
            end else if (instr_win) begin
                mem_we_o    <= 1'b0;
                mem_be_o    <= '1;
                mem_addr_o  <= instr_addr_i;
                mem_wdata_o <= '0;
            end
        end
    end

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cnt_q <= '0;
        end else if (data_win) begin
            if (!instr_valid) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (instr_win) begin
            cnt_q <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            drop_q <= 1'b0;
        end else if (state_q == WAIT_I) begin
            if (mem_rvalid_i) begin
                drop_q <= 1'b0;
            end else if (instr_kill_i) begin
                drop_q <= 1'b1;
            end
        end
    end

    a_no_idle_rvalid: assert property (@(posedge clk_i) disable iff (!arstn_i)
        !((state_q == IDLE) && mem_rvalid_i));

endmodule
